// File: rtl/data_island_packet_scheduler.sv
// Picks one HDMI data-island packet per slot: audio, ACR, AVI, Audio InfoFrame or null.
// Stereo samples are buffered in a small FIFO; one enable pulse goes to the granted generator.
module data_island_packet_scheduler #(
  parameter int AUDIO_FIFO_DEPTH = 4,
  parameter int ACR_PERIOD       = 25200
) (
  input  logic                                 clk_pixel,
  input  logic                                 reset_n,
  input  logic                                 audio_sample_valid,
  input  logic [1:0][23:0]                     audio_sample_word_in,
  input  logic                                 frame_start,
  input  logic                                 packet_slot,
  output logic [7:0]                           packet_type,
  output logic [1:0][23:0]                     audio_sample_word,
  output logic                                 acr_enable,
  output logic                                 audio_enable,
  output logic                                 avi_enable,
  output logic                                 audio_if_enable,
  output logic [$clog2(AUDIO_FIFO_DEPTH):0]    audio_fifo_count,
  output logic                                 audio_overflow
);

  localparam int AW = $clog2(AUDIO_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACR_PERIOD);
  localparam logic [CW-1:0] FULL_C   = CW'(AUDIO_FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_C   = CW'(AUDIO_FIFO_DEPTH / 2);
  localparam logic [TW-1:0] ACR_LAST = TW'(ACR_PERIOD - 1);

  typedef enum logic [2:0] {G_NULL, G_AUDIO, G_ACR, G_AVI, G_AIF} grant_e;

  logic [AUDIO_FIFO_DEPTH-1:0][1:0][23:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] acr_timer;
  logic          acr_pend, avi_pend, aif_pend;
  logic          acr_wrap, full, push, pop;
  grant_e        sel;

  // Arbitration looks only at registered state, so a same-cycle push is not seen.
  always_comb begin
    sel = G_NULL;
    if (audio_fifo_count >= HALF_C)      sel = G_AUDIO;
    else if (acr_pend)                   sel = G_ACR;
    else if (audio_fifo_count != '0)     sel = G_AUDIO;
    else if (avi_pend)                   sel = G_AVI;
    else if (aif_pend)                   sel = G_AIF;
  end

  assign full     = (audio_fifo_count == FULL_C);
  assign pop      = packet_slot && (sel == G_AUDIO);
  assign push     = audio_sample_valid && (!full || pop);
  assign acr_wrap = (acr_timer == ACR_LAST);

  always_ff @(posedge clk_pixel) begin
    if (push) mem[wr_ptr] <= audio_sample_word_in;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      audio_fifo_count <= '0;
      audio_overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   audio_fifo_count <= audio_fifo_count + 1'b1;
        2'b01:   audio_fifo_count <= audio_fifo_count - 1'b1;
        default: audio_fifo_count <= audio_fifo_count;
      endcase
      if (audio_sample_valid && full && !pop) audio_overflow <= 1'b1;
    end
  end

  // A set event wins over a same-cycle grant so no request is lost.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_timer <= '0;
      acr_pend  <= 1'b0;
      avi_pend  <= 1'b0;
      aif_pend  <= 1'b0;
    end else begin
      acr_timer <= acr_wrap ? '0 : acr_timer + 1'b1;
      if (acr_wrap)                                acr_pend <= 1'b1;
      else if (packet_slot && sel == G_ACR)        acr_pend <= 1'b0;
      if (frame_start)                             avi_pend <= 1'b1;
      else if (packet_slot && sel == G_AVI)        avi_pend <= 1'b0;
      if (frame_start)                             aif_pend <= 1'b1;
      else if (packet_slot && sel == G_AIF)        aif_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packet_type       <= 8'h00;
      audio_sample_word <= '0;
      acr_enable        <= 1'b0;
      audio_enable      <= 1'b0;
      avi_enable        <= 1'b0;
      audio_if_enable   <= 1'b0;
    end else begin
      acr_enable      <= packet_slot && (sel == G_ACR);
      audio_enable    <= packet_slot && (sel == G_AUDIO);
      avi_enable      <= packet_slot && (sel == G_AVI);
      audio_if_enable <= packet_slot && (sel == G_AIF);
      if (pop) audio_sample_word <= mem[rd_ptr];
      if (packet_slot) begin
        case (sel)
          G_AUDIO: packet_type <= 8'h02;
          G_ACR:   packet_type <= 8'h01;
          G_AVI:   packet_type <= 8'h82;
          G_AIF:   packet_type <= 8'h84;
          default: packet_type <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Directed bench for data_island_packet_scheduler (DEPTH=4, ACR_PERIOD=100).
module tb_data_island_packet_scheduler;
  logic             clk_pixel = 1'b0;
  logic             reset_n;
  logic             audio_sample_valid;
  logic [1:0][23:0] audio_sample_word_in;
  logic             frame_start;
  logic             packet_slot;
  logic [7:0]       packet_type;
  logic [1:0][23:0] audio_sample_word;
  logic             acr_enable, audio_enable, avi_enable, audio_if_enable;
  logic [2:0]       audio_fifo_count;
  logic             audio_overflow;

  int vecs = 0;
  int errs = 0;

  data_island_packet_scheduler #(.AUDIO_FIFO_DEPTH(4), .ACR_PERIOD(100)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .audio_sample_valid(audio_sample_valid), .audio_sample_word_in(audio_sample_word_in),
    .frame_start(frame_start), .packet_slot(packet_slot),
    .packet_type(packet_type), .audio_sample_word(audio_sample_word),
    .acr_enable(acr_enable), .audio_enable(audio_enable), .avi_enable(avi_enable),
    .audio_if_enable(audio_if_enable), .audio_fifo_count(audio_fifo_count),
    .audio_overflow(audio_overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick();
    @(posedge clk_pixel); #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; audio_sample_valid = 1'b0; audio_sample_word_in = '0;
    frame_start = 1'b0; packet_slot = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
  endtask

  task automatic do_slot();
    packet_slot = 1'b1; tick(); packet_slot = 1'b0;
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    audio_sample_valid = 1'b1; audio_sample_word_in = {r, l};
    tick(); audio_sample_valid = 1'b0;
  endtask

  // enables packed as {acr, audio, avi, audio_if}
  function automatic logic [3:0] ens();
    return {acr_enable, audio_enable, avi_enable, audio_if_enable};
  endfunction

  task automatic test_reset();
    do_reset();
    vecs++; if (packet_type !== 8'h00) begin errs++; $display("FAIL reset_type got %h exp 00", packet_type); end
    vecs++; if (ens() !== 4'b0000) begin errs++; $display("FAIL reset_en got %b exp 0000", ens()); end
    vecs++; if (audio_sample_word !== 48'h0) begin errs++; $display("FAIL reset_word got %h exp 0", audio_sample_word); end
    vecs++; if (audio_fifo_count !== 3'd0 || audio_overflow !== 1'b0) begin errs++; $display("FAIL reset_fifo got cnt=%0d ovf=%b exp 0/0", audio_fifo_count, audio_overflow); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      wait_cycles(31);
      do_slot();
      vecs++; if (packet_type !== 8'h00 || ens() !== 4'b0000 || audio_fifo_count !== 3'd0) begin
        errs++; $display("FAIL idle_slot%0d got type=%h en=%b cnt=%0d exp 00/0000/0", s, packet_type, ens(), audio_fifo_count);
      end
    end
  endtask

  task automatic test_audio_single();
    do_reset();
    push(24'h123456, 24'hABCDEF);
    vecs++; if (audio_fifo_count !== 3'd1) begin errs++; $display("FAIL single_cnt got %0d exp 1", audio_fifo_count); end
    do_slot();
    vecs++; if (ens() !== 4'b0100 || packet_type !== 8'h02) begin errs++; $display("FAIL single_grant got en=%b type=%h exp 0100/02", ens(), packet_type); end
    vecs++; if (audio_sample_word !== {24'hABCDEF, 24'h123456} || audio_fifo_count !== 3'd0) begin
      errs++; $display("FAIL single_word got %h cnt=%0d exp abcdef123456/0", audio_sample_word, audio_fifo_count);
    end
    tick();
    vecs++; if (ens() !== 4'b0000 || packet_type !== 8'h02) begin errs++; $display("FAIL single_hold got en=%b type=%h exp 0000/02", ens(), packet_type); end
  endtask

  task automatic test_infoframes();
    do_reset();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    do_slot();
    vecs++; if (packet_type !== 8'h82 || ens() !== 4'b0010) begin errs++; $display("FAIL if_avi got type=%h en=%b exp 82/0010", packet_type, ens()); end
    do_slot();
    vecs++; if (packet_type !== 8'h84 || ens() !== 4'b0001) begin errs++; $display("FAIL if_aif got type=%h en=%b exp 84/0001", packet_type, ens()); end
    do_slot();
    vecs++; if (packet_type !== 8'h00 || ens() !== 4'b0000) begin errs++; $display("FAIL if_null got type=%h en=%b exp 00/0000", packet_type, ens()); end
  endtask

  task automatic test_acr_priority();
    do_reset();
    push(24'h000001, 24'h100001);            // cycle 1 after release
    wait_cycles(100);                        // ACR wrap at cycle 100
    do_slot();
    vecs++; if (packet_type !== 8'h01 || ens() !== 4'b1000 || audio_fifo_count !== 3'd1) begin
      errs++; $display("FAIL acr_first got type=%h en=%b cnt=%0d exp 01/1000/1", packet_type, ens(), audio_fifo_count);
    end
    push(24'h000002, 24'h100002);
    wait_cycles(100);                        // next wrap at cycle 200
    do_slot();
    vecs++; if (packet_type !== 8'h02 || ens() !== 4'b0100 || audio_sample_word !== {24'h100001, 24'h000001}) begin
      errs++; $display("FAIL acr_half_audio got type=%h en=%b word=%h exp 02/0100/100001000001", packet_type, ens(), audio_sample_word);
    end
    do_slot();
    vecs++; if (packet_type !== 8'h01 || ens() !== 4'b1000 || audio_fifo_count !== 3'd1) begin
      errs++; $display("FAIL acr_after_audio got type=%h en=%b cnt=%0d exp 01/1000/1", packet_type, ens(), audio_fifo_count);
    end
    do_slot();
    vecs++; if (packet_type !== 8'h02 || audio_sample_word !== {24'h100002, 24'h000002} || audio_fifo_count !== 3'd0) begin
      errs++; $display("FAIL acr_drain got type=%h word=%h cnt=%0d exp 02/100002000002/0", packet_type, audio_sample_word, audio_fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [1:0][23:0] exp_words [4];
    exp_words[0] = {24'hB00001, 24'hA00001};
    exp_words[1] = {24'hB00002, 24'hA00002};
    exp_words[2] = {24'hB00003, 24'hA00003};
    exp_words[3] = {24'hB00006, 24'hA00006};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      audio_sample_valid = 1'b1;
      audio_sample_word_in = {24'hB00000 + 24'(i), 24'hA00000 + 24'(i)};
      tick();
    end
    audio_sample_valid = 1'b0;
    vecs++; if (audio_fifo_count !== 3'd4 || audio_overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_fill got cnt=%0d ovf=%b exp 4/1", audio_fifo_count, audio_overflow);
    end
    audio_sample_valid = 1'b1; audio_sample_word_in = {24'hB00006, 24'hA00006};
    packet_slot = 1'b1; tick(); packet_slot = 1'b0; audio_sample_valid = 1'b0;
    vecs++; if (audio_fifo_count !== 3'd4 || audio_sample_word !== {24'hB00000, 24'hA00000} || audio_enable !== 1'b1) begin
      errs++; $display("FAIL ovf_pushpop got cnt=%0d word=%h aen=%b exp 4/b00000a00000/1", audio_fifo_count, audio_sample_word, audio_enable);
    end
    for (int i = 0; i < 4; i++) begin
      do_slot();
      vecs++; if (audio_sample_word !== exp_words[i] || packet_type !== 8'h02 || audio_fifo_count !== 3'(3 - i)) begin
        errs++; $display("FAIL ovf_drain%0d got word=%h type=%h cnt=%0d exp %h/02/%0d", i, audio_sample_word, packet_type, audio_fifo_count, exp_words[i], 3 - i);
      end
    end
  endtask

  task automatic test_reset_midslot();
    do_reset();
    frame_start = 1'b1; push(24'h111111, 24'h222222); frame_start = 1'b0;
    push(24'h333333, 24'h444444);
    do_slot();
    vecs++; if (audio_enable !== 1'b1) begin errs++; $display("FAIL rst_pre_grant got aen=%b exp 1", audio_enable); end
    reset_n = 1'b0; #1;
    vecs++; if (ens() !== 4'b0000 || packet_type !== 8'h00 || audio_sample_word !== 48'h0 || audio_fifo_count !== 3'd0 || audio_overflow !== 1'b0) begin
      errs++; $display("FAIL rst_mid got en=%b type=%h word=%h cnt=%0d ovf=%b exp all 0", ens(), packet_type, audio_sample_word, audio_fifo_count, audio_overflow);
    end
    tick(); reset_n = 1'b1;
    do_slot();
    vecs++; if (packet_type !== 8'h00 || ens() !== 4'b0000) begin errs++; $display("FAIL rst_post_slot got type=%h en=%b exp 00/0000", packet_type, ens()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_audio_single();
    test_infoframes();
    test_acr_priority();
    test_overflow();
    test_reset_midslot();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
